// File: rtl/frame_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// frame_sequencer_pkg
//   Shared definitions for the frame sequencer slice: sequencer state
//   encodings, window-stage operation IDs, error bit positions and a
//   counter-width helper (ceil(log2(n)), never less than one bit).
//   Ports: none (package).
// -----------------------------------------------------------------------------
package frame_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_e;

  // Window operations the sequenced stage may implement.
  localparam logic [0:0] GAUSSIAN_OP = 1'b0;
  localparam logic [0:0] SOBEL_OP    = 1'b1;

  // Sticky error bit positions.
  localparam int ERR_EXTRA_WR = 0;
  localparam int ERR_SNK_FULL = 1;
  localparam int ERR_TIMEOUT  = 2;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int unsigned n);
    if (n <= 32'd1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/frame_sequencer_pixel_counter.sv
// -----------------------------------------------------------------------------
// frame_sequencer_pixel_counter
//   Per-frame pixel counter with synchronous clear and enable. The caller
//   gates the enable so the count never passes MAX_COUNT.
//   Ports:
//     clock, reset  clock and synchronous active-high reset
//     clr_i         clear the count to zero (wins over en_i)
//     en_i          count one pixel this cycle
//     tc_o          count currently equals MAX_COUNT
//     hit_o         this cycle's increment makes the count reach MAX_COUNT
// -----------------------------------------------------------------------------
module frame_sequencer_pixel_counter #(
  parameter int unsigned MAX_COUNT = 16,
  parameter int          CNT_W     = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o,
  output logic hit_o
);

  localparam logic [CNT_W-1:0] ZERO_V = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MAX_COUNT - 32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o  = (cnt_q == MAX_V);
  assign hit_o = en_i & ~clr_i & (cnt_q == LAST_V);

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = ZERO_V;
    end else if (en_i) begin
      cnt_d = cnt_q + ONE_V;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= ZERO_V;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//   Runs one window stage (Gaussian or Sobel) over a sequence of frames.
//   It gates the stage's FIFO handshakes, counts pixels in and out, holds
//   the stage in reset between frames and reports frame/run completion and
//   protocol errors.
//   Optional build macro FRAME_SEQ_TIMEOUT_EN adds a RUN/DRAIN watchdog
//   that sets err[2] and returns to IDLE; without it err[2] is always 0.
//   Ports:
//     clock, reset      clock, synchronous active-high reset
//     start, abort      run control pulses; cfg_frames sampled on start
//                       (0 = continuous)
//     busy              not IDLE
//     frame_done        one-cycle pulse per completed frame
//     run_done          one-cycle pulse when the run completes
//     frame_cnt         frames completed in this run
//     err               sticky {timeout, write-while-full, extra write}
//     op_reset          synchronous reset to the stage
//     src_empty/src_rd_en       source FIFO side
//     stage_rd_en/stage_empty   stage read side
//     stage_wr_en/stage_full    stage write side
//     snk_full/snk_wr_en        sink FIFO side
// -----------------------------------------------------------------------------
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH      = 720,
  parameter int unsigned IMG_HEIGHT     = 540,
  parameter int unsigned FLUSH_CYCLES   = 2,
  parameter int          FRAME_CNT_W    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [FRAME_CNT_W-1:0] cfg_frames,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   run_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [2:0]             err,
  output logic                   op_reset,
  input  logic                   src_empty,
  output logic                   src_rd_en,
  input  logic                   stage_rd_en,
  output logic                   stage_empty,
  input  logic                   stage_wr_en,
  input  logic                   snk_full,
  output logic                   snk_wr_en,
  output logic                   stage_full
);

  localparam int unsigned FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int          PIX_W        = cnt_width(FRAME_PIXELS + 32'd1);
  localparam int          FLUSH_W      = cnt_width(FLUSH_CYCLES);

  localparam logic [FLUSH_W-1:0]     FLUSH_ZERO  = {FLUSH_W{1'b0}};
  localparam logic [FLUSH_W-1:0]     FLUSH_ONE   = FLUSH_W'(1);
  localparam logic [FLUSH_W-1:0]     FLUSH_LAST  = FLUSH_W'(FLUSH_CYCLES - 32'd1);
  localparam logic [FRAME_CNT_W-1:0] FRAMES_ZERO = {FRAME_CNT_W{1'b0}};
  localparam logic [FRAME_CNT_W-1:0] FRAMES_ONE  = FRAME_CNT_W'(1);

  seq_state_e             state_q, state_d;
  logic [FLUSH_W-1:0]     flush_q, flush_d;
  logic [FRAME_CNT_W-1:0] frames_cfg_q, frames_cfg_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]             err_q, err_d;
  logic                   frame_done_q, frame_done_d;
  logic                   run_done_q, run_done_d;

  logic                   run_s, active_s, flush_s;
  logic                   in_tc_s, in_hit_s, out_tc_s, out_hit_s;
  logic                   done_s, last_frame_s, wd_fire_s;
  logic [FRAME_CNT_W-1:0] frame_inc_s;

  assign run_s    = (state_q == RUN);
  assign active_s = (state_q == RUN) | (state_q == DRAIN);
  assign flush_s  = (state_q == FLUSH);

  // Handshake gating between the stage and the two FIFOs.
  assign stage_empty = src_empty | ~run_s | in_tc_s;
  assign src_rd_en   = stage_rd_en & ~stage_empty;
  assign stage_full  = snk_full | ~active_s;
  // out_cnt never exceeds the frame size, so "below FRAME_PIXELS" is ~tc.
  assign snk_wr_en   = stage_wr_en & ~snk_full & ~out_tc_s & active_s;

  frame_sequencer_pixel_counter #(
    .MAX_COUNT (FRAME_PIXELS),
    .CNT_W     (PIX_W)
  ) u_in_cnt (
    .clock (clock),
    .reset (reset),
    .clr_i (flush_s),
    .en_i  (src_rd_en),
    .tc_o  (in_tc_s),
    .hit_o (in_hit_s)
  );

  frame_sequencer_pixel_counter #(
    .MAX_COUNT (FRAME_PIXELS),
    .CNT_W     (PIX_W)
  ) u_out_cnt (
    .clock (clock),
    .reset (reset),
    .clr_i (flush_s),
    .en_i  (snk_wr_en),
    .tc_o  (out_tc_s),
    .hit_o (out_hit_s)
  );

  // Frame ends when the last write lands and all input has been read,
  // even if the final read happens in the same cycle.
  assign done_s       = active_s & out_hit_s & (in_tc_s | in_hit_s);
  assign frame_inc_s  = frame_cnt_q + FRAMES_ONE;
  assign last_frame_s = (frames_cfg_q != FRAMES_ZERO) && !(frame_inc_s < frames_cfg_q);

`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam int              WD_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_ZERO = {WD_W{1'b0}};
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 32'd1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog: idle cycles in RUN/DRAIN, frozen while a FIFO applies backpressure.
  always_comb begin
    wd_d      = wd_q;
    wd_fire_s = 1'b0;
    if (!active_s || src_rd_en || snk_wr_en) begin
      wd_d = WD_ZERO;
    end else if (snk_full || src_empty) begin
      wd_d = wd_q;
    end else if (wd_q == WD_LAST) begin
      wd_fire_s = 1'b1;
      wd_d      = WD_ZERO;
    end else begin
      wd_d = wd_q + WD_ONE;
    end
  end

  // Watchdog register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q <= WD_ZERO;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_fire_s = 1'b0;
`endif

  // Next-state and control decode for the sequencer.
  always_comb begin
    state_d      = state_q;
    flush_d      = flush_q;
    frames_cfg_d = frames_cfg_q;
    frame_cnt_d  = frame_cnt_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    run_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // Abort in the same cycle as start keeps us idle.
        if (start && !abort) begin
          frames_cfg_d = cfg_frames;
          frame_cnt_d  = FRAMES_ZERO;
          err_d        = 3'b000;
          flush_d      = FLUSH_ZERO;
          state_d      = FLUSH;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          flush_d = FLUSH_ZERO;
          state_d = RUN;
        end else begin
          flush_d = flush_q + FLUSH_ONE;
        end
      end
      RUN, DRAIN: begin
        if (done_s) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_inc_s;
          flush_d      = FLUSH_ZERO;
          if (last_frame_s) begin
            run_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = FLUSH;
          end
        end else if (run_s && in_hit_s) begin
          state_d = DRAIN;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort and watchdog expiry end the run without completion pulses.
    if ((abort || wd_fire_s) && (state_q != IDLE)) begin
      state_d      = IDLE;
      frame_done_d = 1'b0;
      run_done_d   = 1'b0;
      frame_cnt_d  = frame_cnt_q;
    end else begin
      state_d = state_d;
    end

    // Dropped writes: beyond the frame, or into a full sink.
    if (stage_wr_en && out_tc_s) begin
      err_d[ERR_EXTRA_WR] = 1'b1;
    end else begin
      err_d[ERR_EXTRA_WR] = err_d[ERR_EXTRA_WR];
    end
    if (stage_wr_en && snk_full) begin
      err_d[ERR_SNK_FULL] = 1'b1;
    end else begin
      err_d[ERR_SNK_FULL] = err_d[ERR_SNK_FULL];
    end
    if (wd_fire_s) begin
      err_d[ERR_TIMEOUT] = 1'b1;
    end else begin
      err_d[ERR_TIMEOUT] = err_d[ERR_TIMEOUT];
    end
  end

  // Sequencer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      flush_q      <= FLUSH_ZERO;
      frames_cfg_q <= FRAMES_ZERO;
      frame_cnt_q  <= FRAMES_ZERO;
      err_q        <= 3'b000;
      frame_done_q <= 1'b0;
      run_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      frames_cfg_q <= frames_cfg_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
      run_done_q   <= run_done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign op_reset   = (state_q == IDLE) | (state_q == FLUSH);
  assign frame_done = frame_done_q;
  assign run_done   = run_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
`timescale 1ns/1ps
module tb_frame_sequencer;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int P   = W * H;
  localparam int FL  = 2;
  localparam int FCW = 8;
  localparam int TO  = 20;

  logic           clock;
  logic           reset;
  logic           start;
  logic           abort;
  logic [FCW-1:0] cfg_frames;
  logic           busy;
  logic           frame_done;
  logic           run_done;
  logic [FCW-1:0] frame_cnt;
  logic [2:0]     err;
  logic           op_reset;
  logic           src_empty;
  logic           src_rd_en;
  logic           stage_rd_en;
  logic           stage_empty;
  logic           stage_wr_en;
  logic           snk_full;
  logic           snk_wr_en;
  logic           stage_full;

  frame_sequencer #(
    .IMG_WIDTH      (W),
    .IMG_HEIGHT     (H),
    .FLUSH_CYCLES   (FL),
    .FRAME_CNT_W    (FCW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .cfg_frames  (cfg_frames),
    .busy        (busy),
    .frame_done  (frame_done),
    .run_done    (run_done),
    .frame_cnt   (frame_cnt),
    .err         (err),
    .op_reset    (op_reset),
    .src_empty   (src_empty),
    .src_rd_en   (src_rd_en),
    .stage_rd_en (stage_rd_en),
    .stage_empty (stage_empty),
    .stage_wr_en (stage_wr_en),
    .snk_full    (snk_full),
    .snk_wr_en   (snk_wr_en),
    .stage_full  (stage_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected frame completions: frame number and whether it ends the run.
  typedef struct {
    int cnt;
    bit last;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Stage model: each accepted read becomes a write 3 cycles later.
  int          pipe[$];
  int          cyc       = 0;
  int          rd_total  = 0;
  int          wr_total  = 0;
  int          wr_issued = 0;
  int          last_act  = 0;
  int unsigned rd_pct    = 100;
  int unsigned empty_pct = 0;
  int unsigned full_pct  = 0;
  bit          inject_mode = 1'b0;
  bit          injected    = 1'b0;

  task automatic check(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic step(input bit do_start, input bit do_abort);
    @(negedge clock);
    start       = do_start;
    abort       = do_abort;
    src_empty   = ($urandom_range(99) < empty_pct);
    snk_full    = ($urandom_range(99) < full_pct);
    stage_rd_en = ($urandom_range(99) < rd_pct);
    #1;
    stage_wr_en = 1'b0;
    if (pipe.size() > 0 && pipe[0] <= cyc && !stage_full) begin
      stage_wr_en = 1'b1;
      void'(pipe.pop_front());
      wr_issued++;
    end else if (inject_mode && !injected && wr_issued == P) begin
      stage_wr_en = 1'b1;
      injected    = 1'b1;
    end
    #1;
    if (src_rd_en) begin
      pipe.push_back(cyc + 3);
      rd_total++;
    end
    if (snk_wr_en) wr_total++;
    if (src_rd_en || snk_wr_en) last_act = cyc;
    if (op_reset) pipe.delete();
    cyc++;
  endtask

  task automatic start_run(input int frames, input int n_exp);
    exp_t e;
    cfg_frames = frames[FCW-1:0];
    for (int k = 1; k <= n_exp; k++) begin
      e.cnt  = k;
      e.last = (frames != 0) && (k == frames);
      exp_q.push_back(e);
    end
    rd_total  = 0;
    wr_total  = 0;
    wr_issued = 0;
    injected  = 1'b0;
    pipe.delete();
    step(1'b1, 1'b0);
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      step(1'b0, 1'b0);
      n++;
    end while (busy && n < budget);
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_bound: still busy after %0d cycles", name, n);
    end
  endtask

  // Monitor: pops expected frame completions and checks per-cycle gating.
  initial begin
    exp_t e;
    int   mon_rd;
    int   mon_wr;
    int   flush_run;
    mon_rd    = 0;
    mon_wr    = 0;
    flush_run = 0;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        mon_rd    = 0;
        mon_wr    = 0;
        flush_run = 0;
      end else begin
        if (frame_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("frame_cnt", frame_cnt, e.cnt);
            check("run_done_with_frame", run_done, e.last);
            check("frame_reads", mon_rd, P);
            check("frame_writes", mon_wr, P);
          end
          mon_rd = 0;
          mon_wr = 0;
        end else if (run_done) begin
          check("run_done_without_frame", 1, 0);
        end
        if (!busy) begin
          mon_rd = 0;
          mon_wr = 0;
        end
        if (src_rd_en) mon_rd++;
        if (snk_wr_en) mon_wr++;
        if (busy && op_reset) begin
          flush_run++;
        end else begin
          if (busy && flush_run != 0) check("flush_len", flush_run, FL);
          flush_run = 0;
        end
        if (snk_full && stage_wr_en) check("write_while_full", snk_wr_en, 0);
        if (busy && !op_reset) begin
          check("stage_full_mirror", stage_full, snk_full);
          if (src_empty) check("stage_empty_when_src_empty", stage_empty, 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, 1 expected 0");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    cfg_frames  = '0;
    src_empty   = 1'b0;
    snk_full    = 1'b0;
    stage_rd_en = 1'b0;
    stage_wr_en = 1'b0;

    // Reset state, with FIFOs and stage requests active so gating is visible.
    repeat (3) step(1'b0, 1'b0);
    check("rst_busy", busy, 0);
    check("rst_op_reset", op_reset, 1);
    check("rst_stage_empty", stage_empty, 1);
    check("rst_stage_full", stage_full, 1);
    check("rst_src_rd_en", src_rd_en, 0);
    check("rst_snk_wr_en", snk_wr_en, 0);
    check("rst_err", err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_run_done", run_done, 0);
    reset = 1'b0;
    step(1'b0, 1'b0);

    // Single frame with free FIFOs.
    start_run(1, 1);
    run_until_idle("single", 500);
    check("single_reads", rd_total, P);
    check("single_writes", wr_total, P);
    check("single_frame_cnt", frame_cnt, 1);
    check("single_err", err, 0);
    check("single_op_reset_idle", op_reset, 1);

    // Three frames, randomly stalled source.
    rd_pct    = 85;
    empty_pct = 25;
    start_run(3, 3);
    run_until_idle("three", 2000);
    check("three_reads", rd_total, 3 * P);
    check("three_writes", wr_total, 3 * P);
    check("three_frame_cnt", frame_cnt, 3);
    check("three_busy", busy, 0);

    // Sink backpressure 50%.
    empty_pct = 0;
    full_pct  = 50;
    start_run(2, 2);
    run_until_idle("backpressure", 2000);
    check("bp_writes", wr_total, 2 * P);
    check("bp_err", err, 0);
    full_pct = 0;
    rd_pct   = 100;

    // Stage issues one write beyond the frame.
    inject_mode = 1'b1;
    start_run(1, 1);
    run_until_idle("extra_wr", 500);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("extra_wr_err", err, 3'b001);
    check("extra_wr_writes", wr_total, P);
    check("extra_wr_frame_cnt", frame_cnt, 1);
    inject_mode = 1'b0;

    // Abort after 7 reads, then a clean run.
    start_run(1, 1);
    n = 0;
    while (rd_total < 7 && n < 200) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("abort_reads_reached", rd_total, 7);
    rd_pct = 0;
    step(1'b0, 1'b1);
    exp_q.delete();
    step(1'b0, 1'b0);
    check("abort_busy", busy, 0);
    check("abort_op_reset", op_reset, 1);
    check("abort_frame_cnt", frame_cnt, 0);
    rd_pct = 100;
    start_run(1, 1);
    run_until_idle("after_abort", 500);
    check("after_abort_err", err, 0);
    check("after_abort_frame_cnt", frame_cnt, 1);
    check("after_abort_reads", rd_total, P);

    // Continuous mode: abort after the second frame, count is held.
    start_run(0, 3);
    n = 0;
    while (!(frame_done && frame_cnt == 2) && n < 2000) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("cont_second_frame_seen", frame_cnt, 2);
    step(1'b0, 1'b1);
    exp_q.delete();
    step(1'b0, 1'b0);
    check("cont_abort_busy", busy, 0);
    check("cont_abort_frame_cnt", frame_cnt, 2);

    // Reset in the middle of a run.
    start_run(2, 2);
    repeat (10) step(1'b0, 1'b0);
    exp_q.delete();
    reset = 1'b1;
    step(1'b0, 1'b0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_op_reset", op_reset, 1);
    reset = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    check("midrst_frame_done", frame_done, 0);

`ifdef FRAME_SEQ_TIMEOUT_EN
    // Stage goes quiet with data available: watchdog ends the run.
    start_run(1, 0);
    n = 0;
    while (rd_total < 5 && n < 200) begin
      step(1'b0, 1'b0);
      n++;
    end
    rd_pct = 0;
    run_until_idle("watchdog", 500);
    check("wd_err", err, 3'b100);
    check("wd_idle_cycles", (cyc - 1) - last_act, TO + 1);
    rd_pct = 100;
`endif

    check("leftover_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Controls one op_padder-style window stage (Gaussian or Sobel) so it processes a run of frames back to back.
- Sits between the source FIFO, the stage and the sink FIFO; gates the stage's FIFO handshakes and counts pixels in and out.
- Issues a per-frame soft reset to the stage, replacing its dead-end terminal state, and reports frame/run completion and protocol errors.

Parameters:
- IMG_WIDTH, 720, pixels per row
- IMG_HEIGHT, 540, rows per frame
- FLUSH_CYCLES, 2, cycles op_reset is held between frames (min 1)
- FRAME_CNT_W, 16, width of frame counters
- TIMEOUT_CYCLES, 65535, watchdog limit (only with FRAME_SEQ_TIMEOUT_EN)

Ports:
- clock  in  1  clock
- reset  in  1  sync active-high reset
- start  in  1  pulse; begins a run (ignored unless IDLE)
- abort  in  1  pulse; ends the run immediately
- cfg_frames  in  FRAME_CNT_W  frames per run, sampled on start; 0 = continuous
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse per completed frame
- run_done  out  1  one-cycle pulse when the run completes
- frame_cnt  out  FRAME_CNT_W  frames completed in the current run
- err  out  3  sticky: [0] extra write, [1] write while sink full, [2] timeout; cleared on start
- op_reset  out  1  active-high sync reset to the stage
- src_empty  in  1  source FIFO empty
- src_rd_en  out  1  source FIFO read
- stage_rd_en  in  1  stage read request
- stage_empty  out  1  empty as seen by the stage
- stage_wr_en  in  1  stage write request
- snk_full  in  1  sink FIFO full
- snk_wr_en  out  1  sink FIFO write
- stage_full  out  1  full as seen by the stage

Behaviour:
- FRAME_PIXELS = IMG_WIDTH*IMG_HEIGHT.
- in_cnt and out_cnt are CLOG2(FRAME_PIXELS+1) bits wide.
- Reset values:
  - state = IDLE; all counters 0; err = 0.
  - busy, frame_done, run_done = 0.
  - op_reset = 1 (stage held in reset while IDLE).
  - stage_empty = 1, stage_full = 1.
  - src_rd_en = 0, snk_wr_en = 0.
- Combinational gating:
  - stage_empty = src_empty | ~(state==RUN) | (in_cnt==FRAME_PIXELS).
  - src_rd_en = stage_rd_en & ~stage_empty.
  - stage_full = snk_full | ~(state==RUN | state==DRAIN).
  - snk_wr_en = stage_wr_en & ~snk_full & (out_cnt<FRAME_PIXELS) & (state==RUN | state==DRAIN).
- Counting:
  - in_cnt increments on src_rd_en; out_cnt increments on snk_wr_en.
  - Write requests are counted raw: the stage's wr_en is pipelined after its own full check.
- States:
  - IDLE: op_reset = 1. On start: latch cfg_frames, clear err and frame_cnt, go to FLUSH.
  - FLUSH: op_reset = 1 for exactly FLUSH_CYCLES cycles. Clears in_cnt and out_cnt, then goes to RUN.
  - RUN: op_reset = 0, stage sees the real FIFO status. When the cycle's increment makes in_cnt reach FRAME_PIXELS, go to DRAIN next cycle.
  - DRAIN: no reads (stage_empty = 1). Writes continue.
  - Frame complete: in RUN or DRAIN, when the increment makes out_cnt reach FRAME_PIXELS and in_cnt==FRAME_PIXELS (including the same cycle):
    - pulse frame_done and increment frame_cnt;
    - if cfg_frames==0 or frame_cnt+1<cfg_frames, go to FLUSH;
    - else pulse run_done and go to IDLE.
- Errors:
  - stage_wr_en while out_cnt==FRAME_PIXELS sets err[0]; the write is dropped.
  - stage_wr_en & snk_full sets err[1]; the write is dropped.
- abort: from any non-IDLE state, go to IDLE next cycle. No frame_done or run_done; frame_cnt is held.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- Reset mid-run: everything returns to reset values; no pulses are emitted.
- frame_cnt wraps modulo 2^FRAME_CNT_W in continuous mode.

Optional Feature:
- Macro FRAME_SEQ_TIMEOUT_EN.
- Defined: a watchdog counts cycles in RUN/DRAIN since the last src_rd_en or snk_wr_en.
  - Reaching TIMEOUT_CYCLES sets err[2] and forces IDLE, same as abort.
  - The watchdog is frozen while snk_full=1 or src_empty=1, so backpressure is not a fault.
- Undefined: no watchdog logic; err[2] is tied to 0.

Decomposition:
- Shared include img_defs.vh holds:
  - the CLOG2 macro;
  - state encodings IDLE=0, FLUSH=1, RUN=2, DRAIN=3;
  - op IDs GAUSSIAN_OP=0, SOBEL_OP=1.
- One natural sub-module, pixel_counter (enable, clear, terminal-count flag), instantiated twice for in_cnt and out_cnt.
- The FSM and gating stay in frame_sequencer.

Test Plan:
- IMG 4x4, cfg_frames=1, loopback stage model with 3-cycle wr latency, free FIFOs -> exactly 16 src_rd_en and 16 snk_wr_en; one frame_done, then run_done the same cycle; frame_cnt=1; op_reset high 2 cycles before RUN.
- cfg_frames=3, source fed continuously -> 3 frame_done pulses, each frame followed by a 2-cycle op_reset; 48 reads total; run_done once; busy low after.
- snk_full toggled 50% pseudo-random -> no snk_wr_en while full, stage_full mirrors snk_full, 16 writes per frame, err=0.
- Stage model issues a 17th wr_en -> dropped; err[0]=1; frame still completes.
- abort asserted after 7 reads -> IDLE next cycle, op_reset=1, no done pulses; a following start completes normally with err cleared.
- FRAME_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=20; stage stops requesting while src_empty=0 -> err[2]=1 at the 20th idle cycle, then IDLE.
